// File: rtl/timebase_generator.sv
// Divides the system clock into one-second and one-minute strobes, with pause,
// fastwatch and a 50 % duty blink for the alarm-clock datapath.
module timebase_generator #(
    parameter int TICKS_PER_SEC = 256,
    parameter int SECS_PER_MIN  = 60,
    localparam int TW = $clog2(TICKS_PER_SEC),
    localparam int SW = $clog2(SECS_PER_MIN)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          reset_count,
    input  logic          enable,
    input  logic          fastwatch,
    output logic          one_second,
    output logic          one_minute,
    output logic          blink,
    output logic [SW-1:0] sec_index
);

    localparam logic [TW-1:0] TICK_MAX  = TW'(TICKS_PER_SEC - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(TICKS_PER_SEC / 2);
    localparam logic [SW-1:0] SEC_MAX   = SW'(SECS_PER_MIN - 1);

    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] sec_cnt;
    logic          sec_pulse;
    logic          min_pulse;

    // Wrap by explicit compare so non-power-of-two parameters never overrun.
    wire tick_wrap = (tick_cnt == TICK_MAX);
    wire sec_wrap  = (sec_cnt == SEC_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset || reset_count) begin
            tick_cnt  <= '0;
            sec_cnt   <= '0;
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
        end else if (!enable) begin
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
        end else if (tick_wrap) begin
            tick_cnt  <= '0;
            sec_pulse <= 1'b1;
            if (sec_wrap) begin
                sec_cnt   <= '0;
                min_pulse <= 1'b1;
            end else begin
                sec_cnt   <= sec_cnt + 1'b1;
                min_pulse <= 1'b0;
            end
        end else begin
            tick_cnt  <= tick_cnt + 1'b1;
            sec_pulse <= 1'b0;
            min_pulse <= 1'b0;
        end
    end

    // Fastwatch only steers the minute strobe; the counters are untouched.
    assign one_second = sec_pulse;
    assign one_minute = fastwatch ? sec_pulse : min_pulse;
    assign blink      = (tick_cnt < TICK_HALF);
    assign sec_index  = sec_cnt;

endmodule

// File: tb/tb_timebase_generator.sv
// Directed bench for timebase_generator: default instance plus a small
// TICKS_PER_SEC=10 / SECS_PER_MIN=3 instance sharing the same clock and reset.
module tb_timebase_generator;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic reset_count = 1'b0;
    logic enable = 1'b1;
    logic fastwatch = 1'b0;

    logic       a_one_second, a_one_minute, a_blink;
    logic [5:0] a_sec_index;

    logic       b_one_second, b_one_minute, b_blink;
    logic [1:0] b_sec_index;

    int checks = 0;
    int errors = 0;
    int n_sec, n_min, n_diff;

    always #5 clock = ~clock;

    timebase_generator dut_a (
        .clock       (clock),
        .reset       (reset),
        .reset_count (reset_count),
        .enable      (enable),
        .fastwatch   (fastwatch),
        .one_second  (a_one_second),
        .one_minute  (a_one_minute),
        .blink       (a_blink),
        .sec_index   (a_sec_index)
    );

    timebase_generator #(.TICKS_PER_SEC(10), .SECS_PER_MIN(3)) dut_b (
        .clock       (clock),
        .reset       (reset),
        .reset_count (1'b0),
        .enable      (1'b1),
        .fastwatch   (1'b0),
        .one_second  (b_one_second),
        .one_minute  (b_one_minute),
        .blink       (b_blink),
        .sec_index   (b_sec_index)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges; outputs are then sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        n_sec  = 0;
        n_min  = 0;
        n_diff = 0;
    endtask

    task automatic run_count(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            if (a_one_second) n_sec++;
            if (a_one_minute) n_min++;
            if (a_one_minute !== a_one_second) n_diff++;
        end
    endtask

    initial begin
        // Reset state of both instances.
        step(2);
        check("rst_a_one_second", 32'(a_one_second), 0);
        check("rst_a_one_minute", 32'(a_one_minute), 0);
        check("rst_a_sec_index",  32'(a_sec_index),  0);
        check("rst_a_blink",      32'(a_blink),      1);
        check("rst_b_one_second", 32'(b_one_second), 0);
        check("rst_b_blink",      32'(b_blink),      1);

        // Small instance: edge k after release.
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            check($sformatf("b_one_second_k%0d", k), 32'(b_one_second), 32'(k % 10 == 0));
            check($sformatf("b_one_minute_k%0d", k), 32'(b_one_minute), 32'(k % 30 == 0));
            check($sformatf("b_blink_k%0d", k),      32'(b_blink),      32'((k % 10) < 5));
            check($sformatf("b_sec_index_k%0d", k),  32'(b_sec_index),  32'((k / 10) % 3));
        end

        // Default instance: first second lands after edge 256.
        step(215);
        check("a_edge255_one_second", 32'(a_one_second), 0);
        check("a_edge255_blink",      32'(a_blink),      0);
        step(1);
        check("a_edge256_one_second", 32'(a_one_second), 1);
        check("a_edge256_one_minute", 32'(a_one_minute), 0);
        check("a_edge256_sec_index",  32'(a_sec_index),  1);
        check("a_edge256_blink",      32'(a_blink),      1);
        step(1);
        check("a_edge257_one_second", 32'(a_one_second), 0);

        // Edges 258..15359: seconds 2..59, no minute yet.
        clear_counts();
        run_count(15102);
        check("a_min1_sec_pulses", 32'(n_sec), 58);
        check("a_min1_min_pulses", 32'(n_min), 0);
        check("a_edge15359_sec_index", 32'(a_sec_index), 59);
        step(1);
        check("a_edge15360_one_minute", 32'(a_one_minute), 1);
        check("a_edge15360_one_second", 32'(a_one_second), 1);
        check("a_edge15360_sec_index",  32'(a_sec_index),  0);

        // Fastwatch for 30 seconds: minute strobe mirrors second strobe.
        fastwatch = 1'b1;
        clear_counts();
        run_count(7680);
        check("fw_mirror_mismatches", 32'(n_diff), 0);
        check("fw_min_pulses",        32'(n_min),  30);
        check("fw_sec_index",         32'(a_sec_index), 30);
        fastwatch = 1'b0;
        #1;
        check("fw_off_one_minute", 32'(a_one_minute), 0);
        check("fw_off_one_second", 32'(a_one_second), 1);
        check("fw_off_sec_index",  32'(a_sec_index),  30);

        // Edges 23041..30719: no minute strobe until edge 30720.
        clear_counts();
        run_count(7679);
        check("a_min2_min_pulses", 32'(n_min), 0);
        check("a_min2_sec_pulses", 32'(n_sec), 29);
        check("a_edge30719_sec_index", 32'(a_sec_index), 59);
        step(1);
        check("a_edge30720_one_minute", 32'(a_one_minute), 1);
        check("a_edge30720_sec_index",  32'(a_sec_index),  0);

        // Pause 100 cycles at tick_cnt=200, then 56 enabled cycles to the strobe.
        step(200);
        check("pause_pre_blink", 32'(a_blink), 0);
        enable = 1'b0;
        clear_counts();
        run_count(100);
        check("pause_sec_pulses", 32'(n_sec), 0);
        check("pause_sec_index",  32'(a_sec_index), 0);
        check("pause_blink",      32'(a_blink), 0);
        enable = 1'b1;
        step(55);
        check("resume55_one_second", 32'(a_one_second), 0);
        step(1);
        check("resume56_one_second", 32'(a_one_second), 1);
        check("resume56_sec_index",  32'(a_sec_index),  1);

        // Enable dropped on the wrap edge: wrap deferred to the next enabled edge.
        step(255);
        enable = 1'b0;
        step(1);
        check("enwrap_hold_one_second", 32'(a_one_second), 0);
        check("enwrap_hold_sec_index",  32'(a_sec_index),  1);
        enable = 1'b1;
        step(1);
        check("enwrap_go_one_second", 32'(a_one_second), 1);
        check("enwrap_go_sec_index",  32'(a_sec_index),  2);

        // reset_count on the wrap edge wins; next second a full 256 later.
        step(255);
        reset_count = 1'b1;
        step(1);
        check("rc_one_second", 32'(a_one_second), 0);
        check("rc_sec_index",  32'(a_sec_index),  0);
        check("rc_blink",      32'(a_blink),      1);
        reset_count = 1'b0;
        step(255);
        check("rc_edge255_one_second", 32'(a_one_second), 0);
        step(1);
        check("rc_edge256_one_second", 32'(a_one_second), 1);
        check("rc_edge256_sec_index",  32'(a_sec_index),  1);

        // Reset while a strobe is high drops it on the next edge.
        reset = 1'b1;
        step(1);
        check("rst_strobe_one_second", 32'(a_one_second), 0);
        check("rst_strobe_sec_index",  32'(a_sec_index),  0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timebase_generator.md
# timebase_generator

Parametrised timebase for the alarm-clock datapath. It divides the system `clock` into single-cycle `one_second` and `one_minute` strobes. It also provides a count-enable (pause), a fastwatch mode, a 50 % duty `blink` signal for display flashing, and the current seconds index. It sits between the clock source and the time/alarm counters, and the alarm controller restarts it through `reset_count` whenever a new current time is loaded.

## Interface
- `TICKS_PER_SEC`, default 256: clock cycles per second. Must be even and ≥ 2.
- `SECS_PER_MIN`, default 60: seconds per minute. Must be ≥ 2.
- Derived widths, not overridable: `TW = clog2(TICKS_PER_SEC)`, `SW = clog2(SECS_PER_MIN)`.

Ports:
- `clock`  in  1  single system clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `reset_count`  in  1  synchronous restart of the timebase, used on time load.
- `enable`  in  1  1 = count; 0 = freeze the counters.
- `fastwatch`  in  1  1 = `one_minute` follows `one_second`.
- `one_second`  out  1  single-cycle strobe, once per second.
- `one_minute`  out  1  single-cycle strobe, once per minute (once per second in fastwatch).
- `blink`  out  1  high during the first half of each second.
- `sec_index`  out  SW  seconds elapsed in the current minute, 0..SECS_PER_MIN-1.

## Operation
- Internal state:
  - `tick_cnt` [TW]: 0..TICKS_PER_SEC-1.
  - `sec_cnt` [SW]: 0..SECS_PER_MIN-1.
  - Registered `sec_pulse` and `min_pulse`.
- Priority on each edge, highest first: `reset` > `reset_count` > `enable`==0 > normal count.
- `reset` or `reset_count`:
  - `tick_cnt`, `sec_cnt` ← 0.
  - `sec_pulse`, `min_pulse` ← 0.
- `enable`==0:
  - Counters hold.
  - `sec_pulse`, `min_pulse` ← 0. No strobes are issued while paused.
- Normal count:
  - If `tick_cnt` == TICKS_PER_SEC-1:
    - `tick_cnt` ← 0 and `sec_pulse` ← 1.
    - If also `sec_cnt` == SECS_PER_MIN-1: `sec_cnt` ← 0 and `min_pulse` ← 1.
    - Otherwise: `sec_cnt` ← `sec_cnt`+1 and `min_pulse` ← 0.
  - Otherwise: `tick_cnt` ← `tick_cnt`+1 and both pulses ← 0.
- `one_second` = `sec_pulse`.
- `one_minute` = `fastwatch` ? `sec_pulse` : `min_pulse`. This mux is combinational.
- `blink` = (`tick_cnt` < TICKS_PER_SEC/2). This is combinational from the register.
- `sec_index` = `sec_cnt`.
- Fastwatch does not alter the counters. Toggling it mid-minute causes no restart, and `sec_index` keeps advancing normally.
- Counter wrap is by explicit compare only. The counters never exceed their maximum, even when the parameter is not a power of two.

## Timing
- Reset values of the outputs:
  - `one_second`=0, `one_minute`=0, `sec_index`=0.
  - `blink`=1, because `tick_cnt`=0.
- Counting starts on the first edge on which `reset`, `reset_count` are low and `enable` is high.
- `one_second`:
  - Goes high for exactly one cycle after the TICKS_PER_SEC-th enabled edge.
  - Period is TICKS_PER_SEC enabled cycles.
- `one_minute` (normal mode):
  - Goes high after the (TICKS_PER_SEC·SECS_PER_MIN)-th enabled edge.
  - It is coincident with the `one_second` of that edge, and `sec_index` reads 0 in that cycle.
- `one_minute` (fastwatch): high in exactly the cycles where `one_second` is high, with zero added latency.
- Pause: cycles with `enable`=0 are not counted. After resume, the next strobe arrives after the remaining enabled cycles.
- `enable` falling on the wrap edge: the wrap does not occur and no strobe is issued. The wrap happens on the first enabled edge afterwards.
- `reset_count` on the wrap edge: the restart wins. No strobe is issued and the next `one_second` comes a full TICKS_PER_SEC enabled cycles later.
- `reset` or `reset_count` asserted with a strobe high: the strobe drops on the next edge.
- `blink` is high for TICKS_PER_SEC/2 cycles and low for TICKS_PER_SEC/2 cycles. It changes on the same edges as `tick_cnt`.

## Test plan
- Default parameters, `enable`=1, `fastwatch`=0, release `reset` → first `one_second` after edge 256, then every 256 cycles; `sec_index` steps 0→1→…→59→0.
- Default parameters, run 15360 enabled cycles → exactly one `one_minute`, coincident with `one_second`, `sec_index`=0 in that cycle; no further `one_minute` before edge 30720.
- `fastwatch`=1 → `one_minute` == `one_second` every cycle; toggle `fastwatch` at `sec_index`=30 → `sec_index` is not disturbed.
- `enable`=0 for 100 cycles at `tick_cnt`=200 → no strobes and `sec_index` holds; after resume, `one_second` arrives 56 enabled cycles later.
- `reset_count` pulsed in the cycle `tick_cnt`=255 → no `one_second`, `sec_index`=0, `blink`=1; next `one_second` 256 cycles later.
- Parameters TICKS_PER_SEC=10, SECS_PER_MIN=3 → `one_second` every 10 cycles, `one_minute` every 30 cycles, `blink` high 5 / low 5 cycles, `sec_index` sequence 0,1,2,0.
